pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/hazard_detect.sv | 24 ++
 rtl/pipe_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pipe_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, ALU op encodings, control-word constants
// and the packed stage write-enable bundle.
package cpu_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 16;

    localparam logic [REG_W-1:0]  REG_XZR  = 5'd31;
    localparam logic [CTRL_W-1:0] CTRL_NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP     = 2'd3
    } seq_state_t;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_ORR    = 4'b0001,
        ALU_ADD    = 4'b0010,
        ALU_SUB    = 4'b0110,
        ALU_PASS_B = 4'b0111,
        ALU_NOR    = 4'b1100
    } alu_op_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stage_we_t;

    localparam stage_we_t WE_ALL  = '1;
    localparam stage_we_t WE_NONE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID source register that matches a load in EX.
// XZR never matches because it is never really written.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0] i_id_rn,
    input  logic [REG_W-1:0] i_id_rm,
    input  logic             i_id_uses_rn,
    input  logic             i_id_uses_rm,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_read_en,
    output logic             o_load_use_c
);

    logic w_rn_hit;
    logic w_rm_hit;

    always_comb begin
        w_rn_hit     = i_id_uses_rn && (i_id_rn == i_ex_rd);
        w_rm_hit     = i_id_uses_rm && (i_id_rm == i_ex_rd);
        o_load_use_c = i_ex_read_en && (i_ex_rd != REG_XZR) && (w_rn_hit || w_rm_hit);
    end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: stage enables, flush/bubble control, memory-wait and
// debug halt/step FSM, plus stall and flush performance counters.
module pipe_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_read_en,
    input  logic             ex_reg_write,
    input  logic             id_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             dbg_halt_req,
    input  logic             dbg_step,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             dbg_halted,
    output logic             mem_err,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      flush_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              r_from_step;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [31:0]       r_stall_cycles;
    logic [15:0]       r_flush_count;
    logic              w_load_use;
    logic              w_mem_wait;
    logic              w_halt_now;
    stage_we_t         w_we;
    logic              w_flush;
    logic              w_bubble;
    logic              w_unused_reg_write;

    // Loads are identified by ex_read_en alone; the write flag is not needed here.
    assign w_unused_reg_write = ex_reg_write;

    hazard_detect u_hazard (
        .i_id_rn      (id_rn),
        .i_id_rm      (id_rm),
        .i_id_uses_rn (id_uses_rn),
        .i_id_uses_rm (id_uses_rm),
        .i_ex_rd      (ex_rd),
        .i_ex_read_en (ex_read_en),
        .o_load_use_c (w_load_use)
    );

    assign w_mem_wait = mem_req && !mem_ready;
    // A single step ignores the still-asserted halt request so it can advance.
    assign w_halt_now = (r_state == ST_RUN) && dbg_halt_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (dbg_halt_req) begin
                    w_next_state = ST_HALTED;
                end
            end
            ST_STEP: begin
                w_next_state = w_mem_wait ? ST_MEM_WAIT : ST_HALTED;
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_next_state = (r_from_step || dbg_halt_req) ? ST_HALTED : ST_RUN;
                end
            end
            ST_HALTED: begin
                if (dbg_step) begin
                    w_next_state = ST_STEP;
                end else if (!dbg_halt_req) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    always_comb begin
        w_we     = WE_ALL;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN, ST_STEP: begin
                    if (w_mem_wait || w_halt_now) begin
                        w_we = WE_NONE;
                    end else if (w_load_use) begin
                        w_we.pc   = 1'b0;
                        w_we.ifid = 1'b0;
                        w_bubble  = 1'b1;
                    end else if (id_br_taken) begin
                        w_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        w_we = WE_NONE;
                    end
                end
                ST_HALTED: w_we = WE_NONE;
                default:   w_we = WE_ALL;
            endcase
        end
    end

    // Wait tracking, sticky timeout and saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_from_step    <= 1'b0;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (r_state != ST_MEM_WAIT) begin
                r_from_step <= (r_state == ST_STEP);
            end
            if ((r_state == ST_MEM_WAIT) && !mem_ready) begin
                if (32'(r_wait_cnt) < MEM_TIMEOUT) begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                if ((32'(r_wait_cnt) + 32'd1) >= MEM_TIMEOUT) begin
                    r_mem_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (!w_we.pc && (r_state != ST_HALTED) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign pc_we        = w_we.pc;
    assign ifid_we      = w_we.ifid;
    assign idex_we      = w_we.idex;
    assign exmem_we     = w_we.exmem;
    assign memwb_we     = w_we.memwb;
    assign ifid_flush   = w_flush;
    assign idex_bubble  = w_bubble;
    assign dbg_halted   = (r_state == ST_HALTED);
    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: expected output words are queued as each
// cycle's stimulus is driven and popped when the outputs are sampled.
module tb_pipe_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rn, id_rm, ex_rd;
    logic        id_uses_rn, id_uses_rm, ex_read_en, ex_reg_write, id_br_taken;
    logic        mem_req, mem_ready, dbg_halt_req, dbg_step;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble;
    logic        dbg_halted, mem_err;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    logic        unused_t2_pc_we, unused_t2_ifid_we, unused_t2_idex_we, unused_t2_exmem_we;
    logic        unused_t2_memwb_we, unused_t2_flush, unused_t2_bubble, unused_t2_halted;
    logic [31:0] unused_t2_stall;
    logic [15:0] unused_t2_fcnt;
    logic        t2_mem_err;

    always #5 clk = ~clk;

    pipe_sequencer dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_read_en(ex_read_en), .ex_reg_write(ex_reg_write), .id_br_taken(id_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .dbg_halt_req(dbg_halt_req),
        .dbg_step(dbg_step), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .memwb_we(memwb_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .dbg_halted(dbg_halted), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_sequencer #(.MEM_TIMEOUT(2)) dut_t2 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_read_en(ex_read_en), .ex_reg_write(ex_reg_write), .id_br_taken(id_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .dbg_halt_req(dbg_halt_req),
        .dbg_step(dbg_step), .pc_we(unused_t2_pc_we), .ifid_we(unused_t2_ifid_we),
        .idex_we(unused_t2_idex_we), .exmem_we(unused_t2_exmem_we),
        .memwb_we(unused_t2_memwb_we), .ifid_flush(unused_t2_flush),
        .idex_bubble(unused_t2_bubble), .dbg_halted(unused_t2_halted), .mem_err(t2_mem_err),
        .stall_cycles(unused_t2_stall), .flush_count(unused_t2_fcnt)
    );

    // Flags: {uses_rn, uses_rm, ex_read_en, br_taken, mem_req, mem_ready, halt_req, step}
    typedef struct packed {
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rd;
        logic [7:0] f;
    } stim_t;

    // Output word: {pc, ifid, idex, exmem, memwb, flush, bubble, halted}
    localparam logic [7:0] O_RUN  = 8'b11111_00_0;
    localparam logic [7:0] O_NONE = 8'b00000_00_0;
    localparam logic [7:0] O_LU   = 8'b00111_01_0;
    localparam logic [7:0] O_BR   = 8'b11111_10_0;
    localparam logic [7:0] O_HALT = 8'b00000_00_1;

    int          n_run  = 0;
    int          n_fail = 0;
    int unsigned m_stall = 0;
    logic [15:0] m_flush = '0;
    logic [7:0]  exp_q[$];

    function automatic stim_t mk(input logic [4:0] rn, input logic [4:0] rm,
                                 input logic [4:0] rd, input logic [7:0] f);
        return {rn, rm, rd, f};
    endfunction

    localparam stim_t IDLE = {5'd1, 5'd2, 5'd9, 8'b11_0_0_0_1_0_0};

    task automatic apply(input stim_t s);
        id_rn        = s.rn;
        id_rm        = s.rm;
        ex_rd        = s.rd;
        id_uses_rn   = s.f[7];
        id_uses_rm   = s.f[6];
        ex_read_en   = s.f[5];
        ex_reg_write = s.f[5];
        id_br_taken  = s.f[4];
        mem_req      = s.f[3];
        mem_ready    = s.f[2];
        dbg_halt_req = s.f[1];
        dbg_step     = s.f[0];
    endtask

    function automatic logic [7:0] outs();
        return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, dbg_halted};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        apply(mk(5'd2, 5'd2, 5'd2, 8'b11_1_1_1_0_1_0));
        @(negedge clk);
        n_run++;
        if (outs() !== O_RUN) begin
            n_fail++; $display("FAIL reset_outs got %b want %b", outs(), O_RUN);
        end
        n_run++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0 || mem_err !== 1'b0 || t2_mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got stall=%0d flush=%0d err=%b/%b want 0 0 0/0",
                     stall_cycles, flush_count, mem_err, t2_mem_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        apply(IDLE);
    endtask

    task automatic test_hazards();
        stim_t      st[8];
        logic [7:0] ex[8];
        logic [7:0] e;
        st[0] = mk(5'd2,  5'd4, 5'd2,  8'b11_1_0_0_1_0_0); ex[0] = O_LU;
        st[1] = IDLE;                                      ex[1] = O_RUN;
        st[2] = mk(5'd31, 5'd5, 5'd31, 8'b11_1_0_0_1_0_0); ex[2] = O_RUN;
        st[3] = mk(5'd1,  5'd2, 5'd9,  8'b11_0_1_0_1_0_0); ex[3] = O_BR;
        st[4] = mk(5'd3,  5'd7, 5'd7,  8'b11_1_1_0_1_0_0); ex[4] = O_LU;
        st[5] = mk(5'd3,  5'd7, 5'd7,  8'b11_0_1_0_1_0_0); ex[5] = O_BR;
        st[6] = mk(5'd6,  5'd1, 5'd6,  8'b01_1_0_0_1_0_0); ex[6] = O_RUN;
        st[7] = IDLE;                                      ex[7] = O_RUN;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (outs() !== e) begin
                n_fail++; $display("FAIL hazards[%0d] outs got %b want %b", i, outs(), e);
            end
            n_run++;
            if (stall_cycles !== m_stall) begin
                n_fail++; $display("FAIL hazards[%0d] stall_cycles got %0d want %0d", i, stall_cycles, m_stall);
            end
            n_run++;
            if (flush_count !== m_flush) begin
                n_fail++; $display("FAIL hazards[%0d] flush_count got %0d want %0d", i, flush_count, m_flush);
            end
            if (!e[7] && !e[0]) m_stall++;
            if (e[2]) m_flush = m_flush + 16'd1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t      st[5];
        logic [7:0] ex[5];
        logic [7:0] e;
        st[0] = mk(5'd1, 5'd2, 5'd9, 8'b11_0_0_1_0_1_0); ex[0] = O_NONE;
        st[1] = mk(5'd1, 5'd2, 5'd9, 8'b11_0_0_1_0_0_0); ex[1] = O_NONE;
        st[2] = mk(5'd1, 5'd2, 5'd9, 8'b11_0_0_1_0_0_0); ex[2] = O_NONE;
        st[3] = mk(5'd3, 5'd7, 5'd7, 8'b11_1_1_1_1_0_0); ex[3] = O_RUN;
        st[4] = IDLE;                                    ex[4] = O_RUN;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (outs() !== e) begin
                n_fail++; $display("FAIL mem_wait[%0d] outs got %b want %b", i, outs(), e);
            end
            n_run++;
            if (stall_cycles !== m_stall) begin
                n_fail++; $display("FAIL mem_wait[%0d] stall_cycles got %0d want %0d", i, stall_cycles, m_stall);
            end
            n_run++;
            if (t2_mem_err !== (i >= 3) || mem_err !== 1'b0) begin
                n_fail++;
                $display("FAIL mem_wait[%0d] mem_err got t2=%b def=%b want t2=%b def=0",
                         i, t2_mem_err, mem_err, (i >= 3));
            end
            if (!e[7] && !e[0]) m_stall++;
            if (e[2]) m_flush = m_flush + 16'd1;
        end
    endtask

    task automatic test_halt_step();
        localparam logic [7:0] H  = 8'b11_0_0_0_1_1_0;
        localparam logic [7:0] HS = 8'b11_0_0_0_1_1_1;
        localparam logic [7:0] I0 = 8'b11_0_0_0_1_0_0;
        logic [7:0] fl[16];
        logic [7:0] ex[16];
        logic [7:0] e;
        fl = '{H, H, HS, H, H, HS, H, H, I0, I0,
               H, HS, 8'b11_0_0_1_0_1_0, 8'b11_0_0_1_1_0_0, I0, I0};
        ex = '{O_NONE, O_HALT, O_HALT, O_RUN, O_HALT, O_HALT, O_RUN, O_HALT, O_HALT, O_RUN,
               O_NONE, O_HALT, O_NONE, O_RUN, O_HALT, O_RUN};
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            apply(mk(5'd1, 5'd2, 5'd9, fl[i]));
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (outs() !== e) begin
                n_fail++; $display("FAIL halt_step[%0d] outs got %b want %b", i, outs(), e);
            end
            n_run++;
            if (stall_cycles !== m_stall) begin
                n_fail++; $display("FAIL halt_step[%0d] stall_cycles got %0d want %0d", i, stall_cycles, m_stall);
            end
            if (!e[7] && !e[0]) m_stall++;
            if (e[2]) m_flush = m_flush + 16'd1;
        end
        n_run++;
        if (flush_count !== m_flush) begin
            n_fail++; $display("FAIL halt_step flush_count got %0d want %0d", flush_count, m_flush);
        end
    endtask

    task automatic test_reset_mid_state();
        @(posedge clk); #1;
        apply(mk(5'd1, 5'd2, 5'd9, 8'b11_0_0_0_1_1_0));
        @(posedge clk); #1;
        @(negedge clk);
        n_run++;
        if (dbg_halted !== 1'b1 || t2_mem_err !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset halted=%b t2_err=%b want 1 1", dbg_halted, t2_mem_err);
        end
        #1 reset = 1'b1;
        #1;
        n_run++;
        if (outs() !== O_RUN) begin
            n_fail++; $display("FAIL reset_in_halted outs got %b want %b", outs(), O_RUN);
        end
        n_run++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0 || t2_mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_halted counters got stall=%0d flush=%0d err=%b want 0 0 0",
                     stall_cycles, flush_count, t2_mem_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        apply(mk(5'd1, 5'd2, 5'd9, 8'b11_0_0_1_0_0_0));
        @(posedge clk); #1;
        @(negedge clk);
        n_run++;
        if (outs() !== O_NONE) begin
            n_fail++; $display("FAIL mem_wait_entry outs got %b want %b", outs(), O_NONE);
        end
        #1 reset = 1'b1;
        #1;
        n_run++;
        if (outs() !== O_RUN) begin
            n_fail++; $display("FAIL reset_in_mem_wait outs got %b want %b", outs(), O_RUN);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        apply(mk(5'd1, 5'd2, 5'd9, 8'b11_0_0_0_0_0_0));
        @(negedge clk);
        n_run++;
        if (outs() !== O_RUN || stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL after_reset outs got %b stall=%0d want %b stall=0", outs(), stall_cycles, O_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_hazards();
        test_mem_wait();
        test_halt_step();
        test_reset_mid_state();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
